serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first, with a single registered borrow bit carried between cycles. It is the inverse-operation companion to the existing bit-level adder cells in the arithmetic datapath. It trades area for latency: one full-subtractor cell plus shift registers replaces a WIDTH-bit ripple subtractor. A start/busy/done handshake connects it to the controlling FSM.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2 to 32.
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `start`  in  1  : request pulse; sampled only in IDLE or DONE.
- `a`  in  WIDTH  : minuend; captured on the accepted `start` edge.
- `b`  in  WIDTH  : subtrahend; captured on the accepted `start` edge.
- `busy`  out  1  : high while in RUN.
- `done`  out  1  : one-cycle pulse when the result is valid.
- `diff`  out  WIDTH  : `(a - b) mod 2^WIDTH`; registered.
- `borrow_out`  out  1  : final borrow; 1 exactly when `a < b` (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE when bit counter equals WIDTH-1.
  - DONE -> RUN if `start` is high; otherwise DONE -> IDLE.
- Accepted start:
  - load shift registers `sa <= a`, `sb <= b`;
  - clear borrow register `br`, counter, and internal result shift register `sd`.
- Each RUN cycle, with `x = sa[0]`, `y = sb[0]`:
  - `d = x ^ y ^ br`;
  - `br_next = (~x & y) | (~(x ^ y) & br)`;
  - `sa`, `sb` shift right;
  - `d` shifts into MSB of `sd`;
  - counter increments.
- On the RUN -> DONE edge:
  - `diff <= {d, sd[WIDTH-1:1]}`;
  - `borrow_out <= br_next`.
- `diff` and `borrow_out` change only on this edge and hold until the next completed operation.
- `start` while in RUN is ignored. Captured operands are unaffected.
- `a` and `b` are don't-care except on the accepted `start` edge.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `diff` 0, `borrow_out` 0, counter 0, `br` 0.
- Define the accepting edge as edge 0:
  - RUN occupies the cycles after edges 0 to WIDTH-1;
  - the state is DONE after edge WIDTH.
- `done` is high exactly one cycle, in the cycle following edge WIDTH.
- Latency is WIDTH cycles from the start edge to `done`.
- `busy` is high for exactly WIDTH cycles, and low in the `done` cycle.
- Back-to-back operation: `start` high in the DONE cycle is accepted.
  - The next `done` follows WIDTH cycles later.
  - Throughput is one result per WIDTH+1 cycles.
  - `diff` from the previous result holds until that next `done`.
- Reset during RUN aborts the operation:
  - no `done` is produced;
  - outputs return to reset values on the next edge.
- Reset takes priority over `start` on the same edge.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `serial_arith_pkg`:
  - state encoding constants `ST_IDLE` = 2'd0, `ST_RUN` = 2'd1, `ST_DONE` = 2'd2;
  - `DEFAULT_WIDTH` = 8.
- Sub-module `full_subtractor`:
  - purely combinational;
  - ports `x`, `y`, `bin`, `d`, `bout`;
  - built from two half-subtractor stages plus an OR gate;
  - one instance per `serial_subtractor`.
- Counter width is `$clog2(WIDTH)`.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, one `start` pulse -> `busy` high 8 cycles; `done` 8 cycles after start; `diff`=0x1E, `borrow_out`=0.
- `a`=0x00, `b`=0x01 -> `diff`=0xFF, `borrow_out`=1. Then `a`=0xA5, `b`=0xA5 -> `diff`=0x00, `borrow_out`=0.
- Start with `a`=0x10, `b`=0x01; pulse `start` with `a`=0xFF, `b`=0x00 at cycle 3 of RUN -> ignored; `done` at cycle 8 with `diff`=0x0F; no second `done`.
- `rst` asserted at cycle 4 of RUN -> next edge gives IDLE, `busy`=0, `diff`=0, `borrow_out`=0; no `done` within 20 cycles.
- `start` held high through the DONE cycle with new operands `a`=0x80, `b`=0x81 -> first result presented; second `done` 8 cycles later with `diff`=0xFF, `borrow_out`=1.
- Randomized 1000 pairs at WIDTH=8 and WIDTH=16 -> `{borrow_out, diff}` equals `{1'b0,a} - {1'b0,b}` each time.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks:
// the controller state encoding and the default operand width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor computing x - y - bin.
// It is built from two half-subtractor stages whose borrows are ORed.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // The first stage computes x - y, and the second stage subtracts the incoming borrow.
    assign d1   = x ^ y;
    assign b1   = ~x & y;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor that computes a - b one bit per clock, LSB first.
// The borrow is held in a register between cycles, and a start/busy/done handshake controls each operation.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-2:0] sd_reg;
    logic [CW-1:0]    cnt_reg;
    logic             br_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;

    full_subtractor u_fs (
        .x    (sa_reg[0]),
        .y    (sb_reg[0]),
        .bin  (br_reg),
        .d    (d_bit),
        .bout (br_next)
    );

    assign last_bit = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: accept = start;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: begin
                accept     = start;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (accept) state_next = ST_RUN;
    end

    // The bit-0 slot of the result is never needed: the final bit is merged in directly when the result is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            sa_reg     <= '0;
            sb_reg     <= '0;
            sd_reg     <= '0;
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                sa_reg  <= a;
                sb_reg  <= b;
                sd_reg  <= '0;
                cnt_reg <= '0;
                br_reg  <= 1'b0;
            end else if (state_reg == ST_RUN) begin
                sa_reg  <= sa_reg >> 1;
                sb_reg  <= sb_reg >> 1;
                sd_reg  <= (WIDTH-1)'({d_bit, sd_reg} >> 1);
                cnt_reg <= cnt_reg + 1'b1;
                br_reg  <= br_next;
                if (last_bit) begin
                    diff_reg   <= {d_bit, sd_reg};
                    borrow_reg <= br_next;
                end
            end
        end
    end

    assign busy       = (state_reg == ST_RUN);
    assign done       = (state_reg == ST_DONE);
    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// A cycle-level reference model is compared against both instances, and directed literal checks are added on top.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  st;
    logic [31:0] av [2];
    logic [31:0] bv [2];
    logic [1:0]  busy_o;
    logic [1:0]  done_o;
    logic [1:0]  bo_o;
    logic [7:0]  diff8;
    logic [15:0] diff16;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
        .busy(busy_o[0]), .done(done_o[0]), .diff(diff8), .borrow_out(bo_o[0])
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[1][15:0]), .b(bv[1][15:0]),
        .busy(busy_o[1]), .done(done_o[1]), .diff(diff16), .borrow_out(bo_o[1])
    );

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic logic [31:0] mask_of(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] get_diff(input int k);
        return (k == 0) ? {24'b0, diff8} : {16'b0, diff16};
    endfunction

    // Reference model: an accepted start begins a run of width_of(k) cycles, and the result appears when the run ends.
    logic [1:0]  m_run;
    logic [1:0]  m_done;
    logic [1:0]  m_bo;
    int          m_left [2];
    logic [31:0] m_diff [2];
    logic [31:0] m_pa [2];
    logic [31:0] m_pb [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k]  <= 1'b0;
                m_done[k] <= 1'b0;
                m_bo[k]   <= 1'b0;
                m_left[k] <= 0;
                m_diff[k] <= '0;
            end else begin
                m_done[k] <= 1'b0;
                if (m_run[k]) begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        m_run[k]  <= 1'b0;
                        m_done[k] <= 1'b1;
                        m_diff[k] <= (m_pa[k] - m_pb[k]) & mask_of(k);
                        m_bo[k]   <= (m_pa[k] < m_pb[k]);
                    end
                end else if (st[k]) begin
                    m_run[k]  <= 1'b1;
                    m_left[k] <= width_of(k);
                    m_pa[k]   <= av[k] & mask_of(k);
                    m_pb[k]   <= bv[k] & mask_of(k);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (busy_o[k] !== m_run[k] || done_o[k] !== m_done[k] ||
                    get_diff(k) !== m_diff[k] || bo_o[k] !== m_bo[k]) begin
                    fails++;
                    $display("FAIL cycle_cmp[w%0d] t=%0t: busy/done/diff/borrow got %b/%b/%h/%b expected %b/%b/%h/%b",
                             width_of(k), $time, busy_o[k], done_o[k], get_diff(k), bo_o[k],
                             m_run[k], m_done[k], m_diff[k], m_bo[k]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic pulse_start(input int k, input logic [31:0] a_v, input logic [31:0] b_v);
        @(posedge clk); #2;
        st[k] = 1'b1; av[k] = a_v; bv[k] = b_v;
        @(posedge clk); #2;
        st[k] = 1'b0;
    endtask

    // Called just after the accepting edge. The number of negedges up to and including the done cycle is WIDTH+1.
    task automatic wait_done(input int k, output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (busy_o[k]) busy_cnt++;
            if (done_o[k]) break;
        end
        if (done_o[k] !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL done_timeout[w%0d]: got done=%b expected 1 within 100 cycles", width_of(k), done_o[k]);
        end
    endtask

    task automatic run_op(input int k, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] exp_d, input logic exp_bo, input string name);
        int cyc, bc;
        pulse_start(k, a_v, b_v);
        wait_done(k, cyc, bc);
        check({name, "_latency"}, cyc - 1, width_of(k));
        check({name, "_busy_cycles"}, bc, width_of(k));
        check({name, "_diff"}, get_diff(k), exp_d);
        check({name, "_borrow"}, {31'b0, bo_o[k]}, {31'b0, exp_bo});
        check({name, "_model"}, m_diff[k], exp_d);
    endtask

    task automatic count_dones(input int k, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done_o[k]) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bc, cnt;
        logic [31:0] ra, rb;
        logic [32:0] e;

        rst = 1'b1; st = 2'b00;
        av[0] = '0; bv[0] = '0; av[1] = '0; bv[1] = '0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'b0, busy_o[0]}, 32'd0);
        check("reset_done", {31'b0, done_o[0]}, 32'd0);
        check("reset_diff", get_diff(0), 32'h0);
        check("reset_borrow", {31'b0, bo_o[0]}, 32'd0);

        run_op(0, 32'h5A, 32'h3C, 32'h1E, 1'b0, "t1_5A_3C");
        run_op(0, 32'h00, 32'h01, 32'hFF, 1'b1, "t2_00_01");
        run_op(0, 32'hA5, 32'hA5, 32'h00, 1'b0, "t2_A5_A5");

        // A start pulse during RUN must be ignored.
        pulse_start(0, 32'h10, 32'h01);
        @(posedge clk); #2;
        @(posedge clk); #2;
        st[0] = 1'b1; av[0] = 32'hFF; bv[0] = 32'h00;
        @(posedge clk); #2;
        st[0] = 1'b0;
        wait_done(0, cyc, bc);
        check("t3_ignored_start_diff", get_diff(0), 32'h0F);
        check("t3_ignored_start_borrow", {31'b0, bo_o[0]}, 32'd0);
        count_dones(0, 20, cnt);
        check("t3_no_second_done", cnt, 0);

        // A reset during RUN aborts the operation.
        pulse_start(0, 32'h33, 32'h11);
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("t4_rst_busy", {31'b0, busy_o[0]}, 32'd0);
        check("t4_rst_diff", get_diff(0), 32'h0);
        check("t4_rst_borrow", {31'b0, bo_o[0]}, 32'd0);
        count_dones(0, 20, cnt);
        check("t4_no_done_after_rst", cnt, 0);

        // Back-to-back: start is held high through the DONE cycle with new operands.
        @(posedge clk); #2;
        st[0] = 1'b1; av[0] = 32'h5A; bv[0] = 32'h3C;
        @(posedge clk); #2;
        wait_done(0, cyc, bc);
        check("t5_first_diff", get_diff(0), 32'h1E);
        av[0] = 32'h80; bv[0] = 32'h81;
        @(posedge clk); #2;
        st[0] = 1'b0;
        wait_done(0, cyc, bc);
        check("t5_b2b_latency", cyc - 1, 8);
        check("t5_second_diff", get_diff(0), 32'hFF);
        check("t5_second_borrow", {31'b0, bo_o[0]}, 32'd1);

        // Random operand pairs, with both extreme cases placed first.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom() & mask_of(k);
                rb = $urandom() & mask_of(k);
                if (i == 0) begin ra = 32'h0; rb = mask_of(k); end
                if (i == 1) begin ra = mask_of(k); rb = 32'h0; end
                e = {1'b0, ra} - {1'b0, rb};
                pulse_start(k, ra, rb);
                wait_done(k, cyc, bc);
                tests++;
                if (get_diff(k) !== (e[31:0] & mask_of(k)) || bo_o[k] !== e[width_of(k)]) begin
                    fails++;
                    $display("FAIL rand[w%0d] %h-%h: got borrow/diff %b/%h expected %b/%h",
                             width_of(k), ra, rb, bo_o[k], get_diff(k), e[width_of(k)], e[31:0] & mask_of(k));
                end
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
